disp_cmd_sched: RTL and testbench

Command scheduler in front of the seven-segment/LED display controller. It accepts display commands from two requesters: the Ethernet receive path (first payload byte of each packet) and the local key handler. It arbitrates between them round-robin and drives the display controller's `eth_data`/`flag` inputs. It pulses `flag` to clear display state on every command change, enforces a minimum hold time, and reverts the display to idle after a configurable inactivity timeout.

---
 rtl/disp_cmd_pkg.sv | 24 ++
 rtl/disp_cmd_slot.sv | 29 ++
 rtl/disp_cmd_sched.sv | 149 ++++++++++++++
 tb/tb_disp_cmd_sched.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/disp_cmd_pkg.sv
// Shared definitions for the display command scheduler.
package disp_cmd_pkg;

  localparam logic [7:0] CMD_IDLE  = 8'h00;
  localparam logic [7:0] CMD_CNT   = 8'hAA;
  localparam logic [7:0] CMD_BLINK = 8'hBB;
  localparam logic [7:0] CMD_ROT   = 8'hCC;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_CLR  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  typedef enum logic {
    SRC_ETH = 1'b0,
    SRC_KEY = 1'b1
  } src_t;

  function automatic logic cmd_valid(input logic [7:0] c);
    return (c == CMD_IDLE) || (c == CMD_CNT) || (c == CMD_BLINK) || (c == CMD_ROT);
  endfunction

endpackage

// File: rtl/disp_cmd_slot.sv
// Single-entry pending command register with overwrite detection.
module disp_cmd_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cap,
  input  logic [7:0] cap_cmd,
  input  logic       clr,
  output logic       pending,
  output logic [7:0] cmd,
  output logic       drop
);

  // A capture that lands on an un-granted pending entry loses the old command.
  assign drop = cap & pending & ~clr;

  // Capture wins over a same-cycle grant clear, so the slot stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      cmd     <= '0;
    end else if (cap) begin
      pending <= 1'b1;
      cmd     <= cap_cmd;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/disp_cmd_sched.sv
// Round-robin command scheduler feeding the display controller.
module disp_cmd_sched
  import disp_cmd_pkg::*;
#(
  parameter int unsigned MIN_HOLD = 1_000_000,
  parameter int unsigned TIMEOUT  = 600_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       eth_rx_valid,
  input  logic       eth_rx_sop,
  input  logic [7:0] eth_rx_byte,
  input  logic       key_req,
  input  logic [7:0] key_cmd,
  output logic [7:0] eth_data,
  output logic       flag,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam logic [31:0] HOLD_LAST = MIN_HOLD - 1;
  localparam logic [31:0] IDLE_LAST = TIMEOUT - 1;

  state_t      state_q, state_d;
  src_t        last_q, last_d;
  logic [31:0] idle_q, idle_d;
  logic [31:0] hold_q, hold_d;
  logic [7:0]  data_d;
  logic        flag_d;

  logic        eth_strobe, eth_ok, eth_bad;
  logic        key_ok, key_bad;
  logic        eth_pend, key_pend;
  logic [7:0]  eth_slot_cmd, key_slot_cmd;
  logic        eth_ovr, key_ovr;
  logic        gnt_eth, gnt_key;
  logic [7:0]  gnt_cmd;
  logic [1:0]  drop_inc;
  logic [8:0]  drop_sum;

  assign eth_strobe = eth_rx_valid & eth_rx_sop;
  assign eth_ok     = eth_strobe & cmd_valid(eth_rx_byte);
  assign eth_bad    = eth_strobe & ~cmd_valid(eth_rx_byte);
  assign key_ok     = key_req & cmd_valid(key_cmd);
  assign key_bad    = key_req & ~cmd_valid(key_cmd);

  disp_cmd_slot u_eth_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .cap     (eth_ok),
    .cap_cmd (eth_rx_byte),
    .clr     (gnt_eth),
    .pending (eth_pend),
    .cmd     (eth_slot_cmd),
    .drop    (eth_ovr)
  );

  disp_cmd_slot u_key_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .cap     (key_ok),
    .cap_cmd (key_cmd),
    .clr     (gnt_key),
    .pending (key_pend),
    .cmd     (key_slot_cmd),
    .drop    (key_ovr)
  );

  // Arbitration, hold/idle sequencing and next output values.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idle_d  = idle_q;
    hold_d  = hold_q;
    data_d  = eth_data;
    flag_d  = 1'b0;
    gnt_eth = 1'b0;
    gnt_key = 1'b0;
    gnt_cmd = eth_slot_cmd;
    case (state_q)
      S_RUN: begin
        if (eth_pend && (!key_pend || last_q == SRC_KEY)) gnt_eth = 1'b1;
        else if (key_pend)                                 gnt_key = 1'b1;
        gnt_cmd = gnt_eth ? eth_slot_cmd : key_slot_cmd;
        if (gnt_eth || gnt_key) begin
          last_d = gnt_eth ? SRC_ETH : SRC_KEY;
          idle_d = '0;
          if (gnt_cmd != eth_data) begin
            data_d  = gnt_cmd;
            flag_d  = 1'b1;
            state_d = S_CLR;
          end
        end else if (TIMEOUT != 0 && idle_q == IDLE_LAST) begin
          idle_d = '0;
          if (eth_data != CMD_IDLE) begin
            data_d  = CMD_IDLE;
            flag_d  = 1'b1;
            state_d = S_CLR;
          end
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end
      S_CLR: begin
        idle_d  = '0;
        hold_d  = '0;
        state_d = (MIN_HOLD == 0) ? S_RUN : S_HOLD;
      end
      S_HOLD: begin
        idle_d = '0;
        if (hold_q == HOLD_LAST) state_d = S_RUN;
        else                     hold_d  = hold_q + 32'd1;
      end
      default: state_d = S_RUN;
    endcase
  end

  // State and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      last_q   <= SRC_KEY;
      idle_q   <= '0;
      hold_q   <= '0;
      eth_data <= CMD_IDLE;
      flag     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      idle_q   <= idle_d;
      hold_q   <= hold_d;
      eth_data <= data_d;
      flag     <= flag_d;
      busy     <= (state_d != S_RUN);
    end
  end

  // Each requester contributes at most one drop per cycle (invalid or overwrite).
  assign drop_inc = {1'b0, eth_bad | eth_ovr} + {1'b0, key_bad | key_ovr};
  assign drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};

  // Saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

endmodule

// File: tb/tb_disp_cmd_sched.sv
// Directed self-checking bench for disp_cmd_sched (MIN_HOLD=4, TIMEOUT=20).
module tb_disp_cmd_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       eth_rx_valid = 1'b0;
  logic       eth_rx_sop = 1'b0;
  logic [7:0] eth_rx_byte = '0;
  logic       key_req = 1'b0;
  logic [7:0] key_cmd = '0;
  logic [7:0] eth_data;
  logic       flag;
  logic       busy;
  logic [7:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  disp_cmd_sched #(.MIN_HOLD(4), .TIMEOUT(20)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .eth_rx_valid (eth_rx_valid),
    .eth_rx_sop   (eth_rx_sop),
    .eth_rx_byte  (eth_rx_byte),
    .key_req      (key_req),
    .key_cmd      (key_cmd),
    .eth_data     (eth_data),
    .flag         (flag),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ev;
    logic       es;
    logic [7:0] eb;
    logic       kr;
    logic [7:0] kc;
    logic [7:0] x_data;
    logic       x_flag;
    logic       x_busy;
    logic [7:0] x_drop;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input logic f,
                         input logic b, input logic [7:0] dc);
    chk({tag, ".eth_data"}, eth_data, d);
    chk({tag, ".flag"}, {7'd0, flag}, {7'd0, f});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
    chk({tag, ".drop_cnt"}, drop_cnt, dc);
  endtask

  // Inputs are held across one rising edge; outputs are sampled 1 ns after it.
  task automatic step(input logic ev, input logic es, input logic [7:0] eb,
                      input logic kr, input logic [7:0] kc);
    eth_rx_valid = ev;
    eth_rx_sop   = es;
    eth_rx_byte  = eb;
    key_req      = kr;
    key_cmd      = kc;
    @(posedge clk);
    #1;
    eth_rx_valid = 1'b0;
    eth_rx_sop   = 1'b0;
    eth_rx_byte  = '0;
    key_req      = 1'b0;
    key_cmd      = '0;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single key 0xAA, then eth 0xBB + key 0xCC tie.
    vt[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hAA, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hAA, 1'b1, 1'b1, 8'h00};
    vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hAA, 1'b0, 1'b1, 8'h00};
    vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hAA, 1'b0, 1'b1, 8'h00};
    vt[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hAA, 1'b0, 1'b1, 8'h00};
    vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hAA, 1'b0, 1'b1, 8'h00};
    vt[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hAA, 1'b0, 1'b0, 8'h00};
    vt[7]  = '{1'b1, 1'b1, 8'hBB, 1'b1, 8'hCC, 8'hAA, 1'b0, 1'b0, 8'h00};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hBB, 1'b1, 1'b1, 8'h00};
    vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hBB, 1'b0, 1'b1, 8'h00};
    vt[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hBB, 1'b0, 1'b1, 8'h00};
    vt[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hBB, 1'b0, 1'b1, 8'h00};
    vt[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hBB, 1'b0, 1'b1, 8'h00};
    vt[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hBB, 1'b0, 1'b0, 8'h00};
    vt[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hCC, 1'b1, 1'b1, 8'h00};
    vt[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hCC, 1'b0, 1'b1, 8'h00};

    do_reset();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 16; i++) begin
      step(vt[i].ev, vt[i].es, vt[i].eb, vt[i].kr, vt[i].kc);
      chk_all($sformatf("vec%0d", i), vt[i].x_data, vt[i].x_flag, vt[i].x_busy, vt[i].x_drop);
    end

    // Invalid codes, non-sop bytes, double drop and saturation.
    do_reset();
    step(1'b1, 1'b1, 8'h55, 1'b0, 8'h00);
    chk("inv_sop.drop", drop_cnt, 8'h01);
    step(1'b1, 1'b0, 8'hAA, 1'b0, 8'h00);
    idle_step();
    idle_step();
    chk_all("nonsop", 8'h00, 1'b0, 1'b0, 8'h01);
    step(1'b1, 1'b1, 8'h12, 1'b1, 8'h34);
    chk("double_drop", drop_cnt, 8'h03);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 8'h55, 1'b0, 8'h00);
    chk_all("saturate", 8'h00, 1'b0, 1'b0, 8'hFF);
    step(1'b1, 1'b1, 8'h01, 1'b1, 8'h02);
    chk("saturate_dbl", drop_cnt, 8'hFF);

    // Same command re-sent: no pulse; then idle timeout 20 cycles after re-grant.
    do_reset();
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'hAA);
    idle_step();
    chk_all("apply_aa", 8'hAA, 1'b1, 1'b1, 8'h00);
    repeat (5) idle_step();
    chk("hold_done.busy", {7'd0, busy}, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'hAA);
    idle_step();
    chk_all("regrant_same", 8'hAA, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k < 20; k++) begin
      idle_step();
      chk($sformatf("idle%0d.flag", k), {7'd0, flag}, 8'h00);
    end
    idle_step();
    chk_all("timeout", 8'h00, 1'b1, 1'b1, 8'h00);

    // Overwrite during hold, then reset mid-hold.
    do_reset();
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'hBB);
    idle_step();
    chk_all("apply_bb", 8'hBB, 1'b1, 1'b1, 8'h00);
    idle_step();
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'hCC);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'hAA);
    chk_all("overwrite", 8'hBB, 1'b0, 1'b1, 8'h01);
    idle_step();
    chk_all("hold_last", 8'hBB, 1'b0, 1'b1, 8'h01);
    idle_step();
    chk_all("hold_exit", 8'hBB, 1'b0, 1'b0, 8'h01);
    idle_step();
    chk_all("apply_aa2", 8'hAA, 1'b1, 1'b1, 8'h01);
    idle_step();
    chk_all("in_hold", 8'hAA, 1'b0, 1'b1, 8'h01);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_step();
    chk_all("post_rst", 8'h00, 1'b0, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
